// File: rtl/hdlverifier_jtag_pkg.sv
// Shared widths, frame field offsets, frame layout and FSM states for the JTAG user-DR decoder.
package hdlverifier_jtag_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FRAME_LEN  = ADDR_WIDTH + DATA_WIDTH + 1;

  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned ADDR_LSB  = DATA_WIDTH;
  localparam int unsigned WFLAG_BIT = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned ERR_BIT   = WFLAG_BIT;

  // Bit counter saturates one past a legal frame so over-long frames stay distinguishable.
  localparam int unsigned CNT_MAX   = FRAME_LEN + 1;
  localparam int unsigned CNT_WIDTH = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } dr_state_e;

  // Same layout serves scan-in {write flag, addr, data} and scan-out {frame_err, addr, rdata}.
  typedef struct packed {
    logic                  flag;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } dr_frame_t;

endpackage

// File: rtl/hdlverifier_jtag_shift_reg.sv
// Frame-wide data register: parallel load on capture, LSB-first serial shift toward bit 0.
module hdlverifier_jtag_shift_reg
  import hdlverifier_jtag_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [FRAME_LEN-1:0] load_val_i,
  input  logic                 shift_i,
  input  logic                 sdi_i,
  output logic [FRAME_LEN-1:0] q_o
);

  logic [FRAME_LEN-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= {sdi_i, sr_q[FRAME_LEN-1:1]};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/hdlverifier_jtag_dr_decoder.sv
// User-DR command stage: assembles a scan frame into addr/wdata/write for the register bank
// and returns the previous read result plus sticky frame-length error on the next scan-out.
module hdlverifier_jtag_dr_decoder
  import hdlverifier_jtag_pkg::*;
(
  input  logic                  tck,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  frame_err
);

  dr_state_e             state_q;
  logic [CNT_WIDTH-1:0]  bitcnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  frame_err_q;

  logic [FRAME_LEN-1:0]  sr;
  dr_frame_t             frame_in;
  dr_frame_t             frame_out;
  logic                  load_c;
  logic                  shift_c;

  // Update outranks capture; capture outranks shift; COMMIT ignores the TAP entirely.
  assign load_c  = sel && capture_dr && !update_dr && (state_q != COMMIT);
  assign shift_c = sel && shift_dr && !capture_dr && !update_dr && (state_q == SHIFT);

  assign frame_out = '{flag: frame_err_q, addr: addr_q, data: rdata};
  assign frame_in  = dr_frame_t'(sr);

  hdlverifier_jtag_shift_reg u_shift_reg (
    .clk_i      (tck),
    .reset_i    (reset),
    .load_i     (load_c),
    .load_val_i (FRAME_LEN'(frame_out)),
    .shift_i    (shift_c),
    .sdi_i      (tdi),
    .q_o        (sr)
  );

  always_ff @(posedge tck) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_c) begin
            bitcnt_q    <= '0;
            frame_err_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!sel) begin
            state_q <= IDLE;
          end else if (update_dr) begin
            if (bitcnt_q == CNT_WIDTH'(FRAME_LEN)) begin
              state_q <= COMMIT;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end else if (capture_dr) begin
            bitcnt_q    <= '0;
            frame_err_q <= 1'b0;
          end else if (shift_dr && (bitcnt_q != CNT_WIDTH'(CNT_MAX))) begin
            bitcnt_q <= bitcnt_q + CNT_WIDTH'(1);
          end
        end
        COMMIT: begin
          addr_q  <= frame_in.addr;
          write_q <= frame_in.flag;
          if (frame_in.flag) begin
            wdata_q <= frame_in.data;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tdo       = sr[0];
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign write     = write_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hdlverifier_jtag_dr_decoder.sv
// Scoreboard bench for the JTAG user-DR decoder with a registered-read register bank model.
module tb_hdlverifier_jtag_dr_decoder;
  import hdlverifier_jtag_pkg::*;

  logic                  tck = 1'b0;
  logic                  reset;
  logic                  sel;
  logic                  capture_dr;
  logic                  shift_dr;
  logic                  update_dr;
  logic                  tdi;
  logic                  tdo;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  frame_err;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  typedef struct {
    bit                   chk;
    logic [FRAME_LEN-1:0] val;
  } scan_t;

  wr_t   exp_wr[$];
  scan_t exp_scan[$];
  wr_t   wr_e;
  scan_t scan_e;

  logic                 prev_write = 1'b0;
  logic [FRAME_LEN-1:0] got_bits   = '0;
  int                   nbits      = 0;

  always #5 tck = ~tck;

  hdlverifier_jtag_dr_decoder dut (
    .tck        (tck),
    .reset      (reset),
    .sel        (sel),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tdi        (tdi),
    .tdo        (tdo),
    .addr       (addr),
    .wdata      (wdata),
    .write      (write),
    .rdata      (rdata),
    .frame_err  (frame_err)
  );

  // Register bank model: synchronous write, read data registered one tck after addr.
  always @(posedge tck) begin
    if (write) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pairs write strobes and completed scan-outs with queued expectations.
  always @(negedge tck) begin
    if (write) begin
      check("write_single_cycle", 64'(prev_write), 64'd0);
      if (exp_wr.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %0h wdata %0h, expected no write", addr, wdata);
      end else begin
        wr_e = exp_wr.pop_front();
        check("write_addr", 64'(addr), 64'(wr_e.addr));
        check("write_wdata", 64'(wdata), 64'(wr_e.data));
      end
    end
    prev_write = write;
    if (sel && update_dr) begin
      if (exp_scan.size() == 0) begin
        total++;
        $display("FAIL unexpected_update: got update, expected none");
      end else begin
        scan_e = exp_scan.pop_front();
        if (scan_e.chk) begin
          check("scan_len", 64'(nbits), 64'(FRAME_LEN));
          check("scan_out", 64'(got_bits), 64'(scan_e.val));
        end
      end
    end else if (sel && capture_dr) begin
      nbits = 0;
    end else if (sel && shift_dr) begin
      if (nbits < int'(FRAME_LEN)) got_bits[nbits] = tdo;
      nbits++;
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic u, input logic d);
    capture_dr = c;
    shift_dr   = s;
    update_dr  = u;
    tdi        = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_range(input logic [39:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(1'b0, 1'b1, 1'b0, v[i]);
  endtask

  task automatic do_frame(input logic [39:0] v, input int n, input bit chk,
                          input logic [FRAME_LEN-1:0] exp_out);
    exp_scan.push_back('{chk, exp_out});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(v, 0, n - 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
  endtask

  function automatic logic [39:0] mk(input logic f, input logic [4:0] a, input logic [31:0] d);
    return {2'b00, f, a, d};
  endfunction

  initial begin
    repeat (5000) @(posedge tck);
    $display("FAIL watchdog: bench still running after 5000 cycles, expected completion");
    $fatal(1);
  end

  initial begin
    logic [39:0] v;
    for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[3] = 32'h1234_5678;
    reset = 1'b1; sel = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
    repeat (3) tick();
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    sel = 1'b1;
    idle(3);

    // Write frame
    exp_wr.push_back('{5'h02, 32'hDEAD_BEEF});
    do_frame(mk(1'b1, 5'h02, 32'hDEAD_BEEF), 38, 1'b1, {1'b0, 5'h00, 32'hA000_0000});
    check("wr_addr", 64'(addr), 64'h02);
    check("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);

    // Read addr 3; scan-out returns the previous addr's data
    do_frame(mk(1'b0, 5'h03, 32'h0), 38, 1'b1, {1'b0, 5'h02, 32'hDEAD_BEEF});
    check("rd_addr", 64'(addr), 64'h03);
    check("rd_wdata_held", 64'(wdata), 64'hDEAD_BEEF);
    do_frame(mk(1'b0, 5'h03, 32'h0), 38, 1'b1, {1'b0, 5'h03, 32'h1234_5678});
    check("rd_frame_err", 64'(frame_err), 64'd0);

    // Short frame
    do_frame(mk(1'b1, 5'h1F, 32'hFFFF_FFFF), 37, 1'b0, '0);
    check("short_frame_err", 64'(frame_err), 64'd1);
    check("short_addr", 64'(addr), 64'h03);
    check("short_wdata", 64'(wdata), 64'hDEAD_BEEF);
    do_frame(mk(1'b0, 5'h03, 32'h0), 38, 1'b1, {1'b1, 5'h03, 32'h1234_5678});
    check("err_cleared", 64'(frame_err), 64'd0);

    // Long frame, bit counter saturation
    exp_scan.push_back('{1'b0, '0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(mk(1'b1, 5'h1F, 32'hFFFF_FFFF), 0, 39);
    check("long_bitcnt_sat", 64'(dut.bitcnt_q), 64'd39);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("long_frame_err", 64'(frame_err), 64'd1);
    check("long_addr", 64'(addr), 64'h03);

    // Pause-DR in the middle of a write frame
    v = mk(1'b1, 5'h05, 32'hCAFE_F00D);
    exp_wr.push_back('{5'h05, 32'hCAFE_F00D});
    exp_scan.push_back('{1'b1, {1'b1, 5'h03, 32'h1234_5678}});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(v, 0, 19);
    idle(5);
    shift_range(v, 20, 37);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("pause_addr", 64'(addr), 64'h05);
    check("pause_wdata", 64'(wdata), 64'hCAFE_F00D);
    check("pause_frame_err", 64'(frame_err), 64'd0);

    // Deselect mid-shift aborts the frame
    v = mk(1'b1, 5'h07, 32'h1111_1111);
    exp_scan.push_back('{1'b0, '0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(v, 0, 9);
    sel = 1'b0;
    drive(1'b0, 1'b1, 1'b0, v[10]);
    sel = 1'b1;
    shift_range(v, 10, 37);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("abort_addr", 64'(addr), 64'h05);
    check("abort_wdata", 64'(wdata), 64'hCAFE_F00D);
    check("abort_frame_err", 64'(frame_err), 64'd0);

    // Reset mid-frame
    exp_scan.push_back('{1'b0, '0});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(mk(1'b1, 5'h09, 32'h5555_5555), 0, 29);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_tdo", 64'(tdo), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_wdata", 64'(wdata), 64'd0);
    check("midrst_write", 64'(write), 64'd0);
    check("midrst_frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("midrst_addr_after_upd", 64'(addr), 64'd0);

    // Capture and update together: update wins and commits
    exp_wr.push_back('{5'h01, 32'h0000_0001});
    exp_scan.push_back('{1'b1, {1'b0, 5'h00, 32'hA000_0000}});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(mk(1'b1, 5'h01, 32'h0000_0001), 0, 37);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("capupd_addr", 64'(addr), 64'h01);

    // Capture-DR re-entered mid-shift restarts the frame
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    shift_range(mk(1'b0, 5'h1F, 32'hFFFF_FFFF), 0, 11);
    exp_wr.push_back('{5'h04, 32'h0BAD_F00D});
    do_frame(mk(1'b1, 5'h04, 32'h0BAD_F00D), 38, 1'b1, {1'b0, 5'h01, 32'h0000_0001});
    check("recap_addr", 64'(addr), 64'h04);
    check("recap_wdata", 64'(wdata), 64'h0BAD_F00D);

    idle(4);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("scan_queue_drained", 64'(exp_scan.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
